fc_access_filter: RTL and testbench

Parametrised write-path filter for the fuse controller's register interface. It replaces the fixed two-range fuse access table with `NumRanges` runtime-programmable, individually lockable ranges, each bound to a requestor ID. It tracks the fuse-address register, checks every fuse-command write against the table for the issuing requestor, and forwards or discards the write. It sits between the AXI-to-register adapter and the fuse controller CSR block.

---
 rtl/fc_access_filter.sv | 199 +++++++++++++++++++
 tb/tb_fc_access_filter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_access_filter.sv
// fc_access_filter: write-path filter in front of the fuse controller CSRs.
// Tracks the fuse-address register, checks every fuse-command write against a
// runtime-programmable, lockable range table bound to requestor IDs, and
// either forwards the write unmodified or discards it and records a violation.
//
// Upstream/downstream handshakes: a transfer happens on a rising edge where
// valid and ready are both high; once raised, out_valid_o and its addr/data
// stay stable until out_ready_i is seen high.
module fc_access_filter #(
    parameter int unsigned NumRanges      = 4,
    parameter int unsigned UserWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter logic [31:0] FuseAddrOffset = 32'h60,
    parameter logic [31:0] FuseCmdOffset  = 32'h64,
    parameter int unsigned CntWidth       = 16,
    localparam int unsigned IdxWidth      = (NumRanges > 1) ? $clog2(NumRanges) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic [UserWidth-1:0] wr_user_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [31:0]          cfg_lower_i,
    input  logic [31:0]          cfg_upper_i,
    input  logic [UserWidth-1:0] cfg_user_i,
    input  logic                 cfg_lock_i,
    output logic [NumRanges-1:0] entry_valid_o,
    output logic [NumRanges-1:0] entry_lock_o,
    output logic                 violation_o,
    output logic [UserWidth-1:0] violation_user_o,
    output logic [CntWidth-1:0]  violation_cnt_o
);

    localparam logic [AddrWidth-1:0] AddrOff = AddrWidth'(FuseAddrOffset);
    localparam logic [AddrWidth-1:0] CmdOff  = AddrWidth'(FuseCmdOffset);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        FWD     = 2'd2,
        DISCARD = 2'd3
    } state_e;

    // Access table
    logic [31:0]          lower_q [NumRanges];
    logic [31:0]          upper_q [NumRanges];
    logic [UserWidth-1:0] user_q  [NumRanges];
    logic [NumRanges-1:0] valid_q;
    logic [NumRanges-1:0] lock_q;

    // Request / FSM state
    state_e               state_q;
    logic                 wr_ready_q;
    logic [AddrWidth-1:0] req_addr_q;
    logic [DataWidth-1:0] req_data_q;
    logic [UserWidth-1:0] req_user_q;
    logic [AddrWidth-1:0] fuse_addr_q;
    logic                 fuse_addr_vld_q;
    logic                 out_valid_q;
    logic [AddrWidth-1:0] out_addr_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 viol_q;
    logic [UserWidth-1:0] viol_user_q;
    logic [CntWidth-1:0]  viol_cnt_q;

    logic [31:0]          fuse_addr_32;
    logic                 match_any;
    logic                 permit;

    assign fuse_addr_32 = 32'(fuse_addr_q);

    // Table programming: only unlocked, in-range entries accept a write; locks stick until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRanges); i++) begin
                lower_q[i] <= '0;
                upper_q[i] <= '0;
                user_q[i]  <= '0;
            end
            valid_q <= '0;
            lock_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NumRanges); i++) begin
                if (cfg_we_i && (int'(cfg_idx_i) == i) && !lock_q[i]) begin
                    lower_q[i] <= cfg_lower_i;
                    upper_q[i] <= cfg_upper_i;
                    user_q[i]  <= cfg_user_i;
                    valid_q[i] <= 1'b1;
                    lock_q[i]  <= cfg_lock_i;
                end
            end
        end
    end

    // Range match for the pending request against the current (pre-write) table.
    always_comb begin
        match_any = 1'b0;
        for (int i = 0; i < int'(NumRanges); i++) begin
            if (valid_q[i] && (user_q[i] == req_user_q) &&
                (lower_q[i] <= fuse_addr_32) && (fuse_addr_32 <= upper_q[i])) begin
                match_any = 1'b1;
            end
        end
        // Non-command writes always pass; commands need a fresh address and a match.
        permit = (req_addr_q != CmdOff) || (fuse_addr_vld_q && match_any);
    end

    // Filter FSM with registered handshake and violation outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            wr_ready_q      <= 1'b1;
            req_addr_q      <= '0;
            req_data_q      <= '0;
            req_user_q      <= '0;
            fuse_addr_q     <= '0;
            fuse_addr_vld_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_addr_q      <= '0;
            out_data_q      <= '0;
            viol_q          <= 1'b0;
            viol_user_q     <= '0;
            viol_cnt_q      <= '0;
        end else begin
            viol_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_valid_i) begin
                        req_addr_q <= wr_addr_i;
                        req_data_q <= wr_data_i;
                        req_user_q <= wr_user_i;
                        // Address tracking happens at acceptance, independent of forwarding.
                        if (wr_addr_i == AddrOff) begin
                            fuse_addr_q     <= wr_data_i[AddrWidth-1:0];
                            fuse_addr_vld_q <= 1'b1;
                        end
                        wr_ready_q <= 1'b0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    // Each command consumes the tracked address, whatever the verdict.
                    if (req_addr_q == CmdOff) begin
                        fuse_addr_vld_q <= 1'b0;
                    end
                    if (permit) begin
                        out_valid_q <= 1'b1;
                        out_addr_q  <= req_addr_q;
                        out_data_q  <= req_data_q;
                        state_q     <= FWD;
                    end else begin
                        viol_q      <= 1'b1;
                        viol_user_q <= req_user_q;
                        if (viol_cnt_q != '1) begin
                            viol_cnt_q <= viol_cnt_q + CntWidth'(1);
                        end
                        state_q <= DISCARD;
                    end
                end
                FWD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        wr_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                DISCARD: begin
                    wr_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    wr_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign wr_ready_o       = wr_ready_q;
    assign out_valid_o      = out_valid_q;
    assign out_addr_o       = out_addr_q;
    assign out_data_o       = out_data_q;
    assign entry_valid_o    = valid_q;
    assign entry_lock_o     = lock_q;
    assign violation_o      = viol_q;
    assign violation_user_o = viol_user_q;
    assign violation_cnt_o  = viol_cnt_q;

endmodule

// File: tb/tb_fc_access_filter.sv
// Bench for fc_access_filter: directed scenarios plus randomized traffic
// checked against a rule-level model of the access table and address tracking.
module tb_fc_access_filter;

    localparam int NR      = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [31:0] A_OFF = 32'h60;
    localparam logic [31:0] C_OFF = 32'h64;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [31:0]   wr_addr_i = '0;
    logic [31:0]   wr_data_i = '0;
    logic [31:0]   wr_user_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [31:0]   out_addr_o;
    logic [31:0]   out_data_o;
    logic          cfg_we_i = 1'b0;
    logic [1:0]    cfg_idx_i = '0;
    logic [31:0]   cfg_lower_i = '0;
    logic [31:0]   cfg_upper_i = '0;
    logic [31:0]   cfg_user_i = '0;
    logic          cfg_lock_i = 1'b0;
    logic [NR-1:0] entry_valid_o;
    logic [NR-1:0] entry_lock_o;
    logic          violation_o;
    logic [31:0]   violation_user_o;
    logic [CW-1:0] violation_cnt_o;

    fc_access_filter #(.NumRanges(NR), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_user_i(wr_user_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_data_o(out_data_o),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
        .cfg_lower_i(cfg_lower_i), .cfg_upper_i(cfg_upper_i),
        .cfg_user_i(cfg_user_i), .cfg_lock_i(cfg_lock_i),
        .entry_valid_o(entry_valid_o), .entry_lock_o(entry_lock_o),
        .violation_o(violation_o), .violation_user_o(violation_user_o),
        .violation_cnt_o(violation_cnt_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Counters and scoreboard
    int n_checks = 0;
    int n_err    = 0;
    int n_xfer   = 0;
    int exp_fwd  = 0;
    logic [63:0] exp_q[$];

    // Reference model: table contents, tracked fuse address, violation record
    logic [31:0] m_lo   [NR];
    logic [31:0] m_hi   [NR];
    logic [31:0] m_user [NR];
    bit          m_valid[NR];
    bit          m_lock [NR];
    logic [31:0] m_fa;
    bit          m_fa_vld;
    int          m_cnt;
    logic [31:0] m_vuser;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Count downstream transfers
    always @(posedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) n_xfer++;
    end

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_lo[i] = '0; m_hi[i] = '0; m_user[i] = '0;
            m_valid[i] = 1'b0; m_lock[i] = 1'b0;
        end
        m_fa = '0; m_fa_vld = 1'b0; m_cnt = 0; m_vuser = '0;
        exp_q.delete();
    endtask

    function automatic logic [NR-1:0] model_valid_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [NR-1:0] model_lock_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_lock[i];
        return v;
    endfunction

    task automatic check_reset_values();
        check_eq("rst_wr_ready", wr_ready_o, 1);
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_out_addr", out_addr_o, 0);
        check_eq("rst_out_data", out_data_o, 0);
        check_eq("rst_violation", violation_o, 0);
        check_eq("rst_viol_user", violation_user_o, 0);
        check_eq("rst_viol_cnt", violation_cnt_o, 0);
        check_eq("rst_entry_valid", entry_valid_o, 0);
        check_eq("rst_entry_lock", entry_lock_o, 0);
    endtask

    // Reset; entered and left at a falling edge
    task automatic do_reset();
        rst_ni = 1'b0;
        wr_valid_i = 1'b0;
        cfg_we_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        model_clear();
    endtask

    // Table write; entered and left at a falling edge
    task automatic cfg_write(input int idx, input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] u, input bit lock);
        cfg_we_i = 1'b1;
        cfg_idx_i = 2'(idx);
        cfg_lower_i = lo; cfg_upper_i = hi; cfg_user_i = u; cfg_lock_i = lock;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        if (idx < NR && !m_lock[idx]) begin
            m_lo[idx] = lo; m_hi[idx] = hi; m_user[idx] = u;
            m_valid[idx] = 1'b1; m_lock[idx] = lock;
        end
        check_eq("cfg_entry_valid", entry_valid_o, model_valid_vec());
        check_eq("cfg_entry_lock", entry_lock_o, model_lock_vec());
    endtask

    // Decide a write's fate from the table rules; returns 1 if it is forwarded
    task automatic model_decide(input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] u, output bit fwd);
        bit hit;
        fwd = 1'b1;
        if (a == A_OFF) begin
            m_fa = d; m_fa_vld = 1'b1;
        end else if (a == C_OFF) begin
            hit = 1'b0;
            for (int i = 0; i < NR; i++)
                if (m_valid[i] && m_user[i] == u && m_lo[i] <= m_fa && m_fa <= m_hi[i]) hit = 1'b1;
            fwd = m_fa_vld && hit;
            m_fa_vld = 1'b0;
        end
        if (fwd) begin
            exp_q.push_back({a, d});
            exp_fwd++;
        end else begin
            m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_vuser = u;
        end
    endtask

    // One upstream write with cycle-exact checks; entered and left at a falling edge
    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] u, input int stall);
        bit fwd;
        int k;
        logic [63:0] exp;
        k = 0;
        while (!wr_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!wr_ready_o) begin
            check_eq("ready_timeout", wr_ready_o, 1);
            return;
        end
        model_decide(a, d, u, fwd);
        out_ready_i = (stall == 0);
        wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_user_i = u;
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        check_eq("check_wr_ready", wr_ready_o, 0);
        check_eq("check_out_valid", out_valid_o, 0);
        @(negedge clk_i);
        if (fwd) begin
            exp = exp_q.pop_front();
            check_eq("fwd_valid", out_valid_o, 1);
            check_eq("fwd_addr", out_addr_o, exp[63:32]);
            check_eq("fwd_data", out_data_o, exp[31:0]);
            check_eq("fwd_no_viol", violation_o, 0);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk_i);
                check_eq("stall_valid", out_valid_o, 1);
                check_eq("stall_addr", out_addr_o, exp[63:32]);
                check_eq("stall_data", out_data_o, exp[31:0]);
                check_eq("stall_wr_ready", wr_ready_o, 0);
            end
            out_ready_i = 1'b1;
            @(negedge clk_i);
            check_eq("fwd_done_valid", out_valid_o, 0);
            check_eq("fwd_done_ready", wr_ready_o, 1);
        end else begin
            check_eq("disc_viol", violation_o, 1);
            check_eq("disc_viol_user", violation_user_o, m_vuser);
            check_eq("disc_viol_cnt", violation_cnt_o, m_cnt);
            check_eq("disc_no_out", out_valid_o, 0);
            @(negedge clk_i);
            check_eq("disc_pulse_end", violation_o, 0);
            check_eq("disc_done_ready", wr_ready_o, 1);
        end
    endtask

    initial begin
        int r;
        logic [31:0] lo;
        model_clear();
        do_reset();
        check_reset_values();

        // Matching requestor: address and command both forwarded
        cfg_write(0, 32'h0, 32'hFFFF, 32'd1, 1'b0);
        send(A_OFF, 32'h40, 32'd1, 0);
        send(C_OFF, 32'hA5A5, 32'd1, 0);

        // Wrong requestor: address forwarded, command discarded
        send(A_OFF, 32'h40, 32'd2, 0);
        send(C_OFF, 32'hA5A5, 32'd2, 0);
        check_eq("viol_user_2", violation_user_o, 2);
        check_eq("viol_cnt_1", violation_cnt_o, 1);

        // Inclusive lower bound
        cfg_write(1, 32'h88, 32'hFFFF, 32'd3, 1'b0);
        send(A_OFF, 32'h80, 32'd3, 0);
        send(C_OFF, 32'h1, 32'd3, 0);
        send(A_OFF, 32'h88, 32'd3, 0);
        send(C_OFF, 32'h2, 32'd3, 0);

        // Lock entry 0, then attempt to rebind it to user 5
        cfg_write(0, 32'h0, 32'hFFFF, 32'd1, 1'b1);
        cfg_write(0, 32'h0, 32'hFFFF, 32'd5, 1'b0);
        check_eq("lock0_set", entry_lock_o[0], 1);
        send(A_OFF, 32'h40, 32'd1, 0);
        send(C_OFF, 32'h3, 32'd1, 0);
        send(A_OFF, 32'h40, 32'd5, 0);
        send(C_OFF, 32'h4, 32'd5, 0);

        // Reset clears table and locks
        do_reset();
        check_reset_values();

        // Index beyond the table is ignored
        cfg_write(3, 32'h0, 32'hFFFF, 32'd1, 1'b1);
        check_eq("oob_idx_valid", entry_valid_o, 0);

        // Command without address, then two commands after one address
        cfg_write(2, 32'h0, 32'hFFFF, 32'd1, 1'b0);
        send(C_OFF, 32'h5, 32'd1, 0);
        send(A_OFF, 32'h100, 32'd1, 0);
        send(C_OFF, 32'h6, 32'd1, 0);
        send(C_OFF, 32'h7, 32'd1, 0);

        // Long downstream stall
        send(32'h20, 32'hDEADBEEF, 32'd1, 10);

        // Randomized traffic from a clean table
        do_reset();
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                lo = 32'($urandom_range(0, 'h100));
                cfg_write(int'($urandom_range(0, 3)), lo, lo + 32'($urandom_range(0, 'h100)),
                          32'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0));
            end else if (r < 5) begin
                send(A_OFF, 32'($urandom_range(0, 'h220)), 32'($urandom_range(1, 3)),
                     int'($urandom_range(0, 2)));
            end else if (r < 9) begin
                send(C_OFF, $urandom, 32'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
            end else begin
                send(32'h10 + 32'(4 * $urandom_range(0, 7)), $urandom,
                     32'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
            end
        end

        // Drive the counter into saturation
        for (int n = 0; n < CNT_MAX + 4; n++) begin
            send(C_OFF, 32'(n), 32'd2, 0);
        end
        check_eq("cnt_saturated", violation_cnt_o, CNT_MAX);

        // Reset mid-transaction: tracked address is dropped as well
        wr_valid_i = 1'b1; wr_addr_i = A_OFF; wr_data_i = 32'h40; wr_user_i = 32'd1;
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        do_reset();
        check_reset_values();
        cfg_write(0, 32'h0, 32'hFFFF, 32'd1, 1'b0);
        send(C_OFF, 32'h9, 32'd1, 0);

        check_eq("xfer_count", n_xfer, exp_fwd);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
